// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup and execute-update bundle of the branch target buffer.
// Valid_E qualifies PC_E/PC_Target_E/Branch_Taken_E/Predict_Taken_E for one cycle; there is no back-pressure.
interface branch_predict_unit_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      PC_F;
    logic [31:0]      PC_E;
    logic [31:0]      PC_Target_E;
    logic             Valid_E;
    logic             Branch_Taken_E;
    logic             Predict_Taken_E;
    logic             Flush_BTB;
    logic             Hit_F;
    logic             Predict_Taken_F;
    logic [31:0]      PC_Prediction_F;
    logic [CNT_W-1:0] Mispredict_Count;

    modport master (
        output PC_F, PC_E, PC_Target_E, Valid_E, Branch_Taken_E, Predict_Taken_E, Flush_BTB,
        input  Hit_F, Predict_Taken_F, PC_Prediction_F, Mispredict_Count
    );

    modport slave (
        input  PC_F, PC_E, PC_Target_E, Valid_E, Branch_Taken_E, Predict_Taken_E, Flush_BTB,
        output Hit_F, Predict_Taken_F, PC_Prediction_F, Mispredict_Count
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters
// and a saturating mispredict statistics counter.
module branch_predict_unit #(
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    branch_predict_unit_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_cnt    [ENTRIES];
    logic [CNT_W-1:0]   r_mis_cnt;

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic [IDX_W-1:0] w_e_idx;
    logic [TAG_W-1:0] w_e_tag;
    logic             w_e_hit;
    logic [1:0]       w_cnt_next;
    logic             w_mispredict;
    logic             w_unused_pc;

    assign w_f_idx = bus.PC_F[IDX_W+1:2];
    assign w_f_tag = bus.PC_F[31:IDX_W+2];
    assign w_e_idx = bus.PC_E[IDX_W+1:2];
    assign w_e_tag = bus.PC_E[31:IDX_W+2];
    assign w_unused_pc = ^{bus.PC_F[1:0], bus.PC_E[1:0]};

    // Lookup reads the registered arrays, so a same-cycle update is seen only next cycle.
    assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    assign w_e_hit = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);

    assign bus.Hit_F           = w_f_hit;
    assign bus.Predict_Taken_F = w_f_hit & r_cnt[w_f_idx][1];
    assign bus.PC_Prediction_F = w_f_hit ? r_target[w_f_idx] : 32'h0;
    assign bus.Mispredict_Count = r_mis_cnt;

    always_comb begin
        w_cnt_next = r_cnt[w_e_idx];
        if (bus.Branch_Taken_E) begin
            if (r_cnt[w_e_idx] != 2'b11) w_cnt_next = r_cnt[w_e_idx] + 2'd1;
        end else begin
            if (r_cnt[w_e_idx] != 2'b00) w_cnt_next = r_cnt[w_e_idx] - 2'd1;
        end
    end

    assign w_mispredict = bus.Valid_E && (bus.Predict_Taken_E != bus.Branch_Taken_E);

    // A flush discards any coincident hit update or allocation entirely.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= 32'h0;
                r_cnt[i]    <= 2'b10;
            end
        end else if (bus.Flush_BTB) begin
            r_valid <= '0;
        end else if (bus.Valid_E) begin
            if (w_e_hit) begin
                r_cnt[w_e_idx] <= w_cnt_next;
                if (bus.Branch_Taken_E) r_target[w_e_idx] <= bus.PC_Target_E;
            end else if (bus.Branch_Taken_E) begin
                r_valid[w_e_idx]  <= 1'b1;
                r_tag[w_e_idx]    <= w_e_tag;
                r_target[w_e_idx] <= bus.PC_Target_E;
                r_cnt[w_e_idx]    <= 2'b10;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_mis_cnt <= '0;
        end else if (w_mispredict && (r_mis_cnt != {CNT_W{1'b1}})) begin
            r_mis_cnt <= r_mis_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Scenario bench for branch_predict_unit: lookups and counter values are queued
// as expectations when driven and popped when the outputs are sampled.
module tb_branch_predict_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    branch_predict_unit_if #(.CNT_W(16)) bi ();
    branch_predict_unit_if #(.CNT_W(4))  bs ();

    branch_predict_unit #(.ENTRIES(16), .CNT_W(16)) dut (
        .CLK(clk), .RST(rst_n), .bus(bi)
    );
    branch_predict_unit #(.ENTRIES(16), .CNT_W(4)) dut_sat (
        .CLK(clk), .RST(rst_n), .bus(bs)
    );

    logic [33:0] exp_q[$];
    logic [15:0] cnt_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] mis_exp = 16'h0;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        bi.Valid_E   = 1'b0;
        bi.Flush_BTB = 1'b0;
        bs.Valid_E   = 1'b0;
    endtask

    task automatic drive_update(input logic [31:0] pc, input logic [31:0] tgt,
                                input logic taken, input logic pred);
        bi.Valid_E         = 1'b1;
        bi.PC_E            = pc;
        bi.PC_Target_E     = tgt;
        bi.Branch_Taken_E  = taken;
        bi.Predict_Taken_E = pred;
        if ((pred != taken) && (mis_exp != 16'hFFFF)) mis_exp = mis_exp + 16'd1;
    endtask

    task automatic expect_lookup(input logic [31:0] pc, input logic hit, input logic pt,
                                 input logic [31:0] tgt);
        bi.PC_F = pc;
        exp_q.push_back({hit, pt, tgt});
    endtask

    task automatic expect_count();
        cnt_q.push_back(mis_exp);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [31:0] pcs[3];
        logic [33:0] got, exp;
        logic [15:0] ce;
        pcs = '{32'h0, 32'h40, 32'hFFFF_FFFC};
        for (int i = 0; i < 3; i++) begin
            expect_lookup(pcs[i], 1'b0, 1'b0, 32'h0);
            #1;
            exp = exp_q.pop_front();
            got = {bi.Hit_F, bi.Predict_Taken_F, bi.PC_Prediction_F};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL reset_lookup pc=%h: got %h want %h", pcs[i], got, exp);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        expect_lookup(32'h0, 1'b0, 1'b0, 32'h0);
        expect_count();
        #1;
        exp = exp_q.pop_front();
        got = {bi.Hit_F, bi.Predict_Taken_F, bi.PC_Prediction_F};
        ce  = cnt_q.pop_front();
        n_vec += 2;
        if (got !== exp) begin
            n_err++;
            $display("FAIL cold_lookup: got %h want %h", got, exp);
        end
        if (bi.Mispredict_Count !== ce) begin
            n_err++;
            $display("FAIL reset_count: got %h want %h", bi.Mispredict_Count, ce);
        end
    endtask

    task automatic test_allocate();
        logic [33:0] got, exp;
        drive_update(32'h0, 32'h4, 1'b1, 1'b0);
        expect_lookup(32'h0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) begin
            #1;
            exp = exp_q.pop_front();
            got = {bi.Hit_F, bi.Predict_Taken_F, bi.PC_Prediction_F};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL allocate_step%0d: got %h want %h", i, got, exp);
            end
            if (i == 0) begin
                tick();
                expect_lookup(32'h0, 1'b1, 1'b1, 32'h4);
            end
        end
    endtask

    task automatic test_counter_walk();
        logic        tk[8], pr[8], ept[8];
        logic [31:0] tg[8], etg[8];
        logic [33:0] got, exp;
        logic [15:0] ce;
        tk  = '{1, 1, 0, 0, 0, 0, 1, 1};
        pr  = '{1, 1, 1, 0, 0, 0, 0, 1};
        tg  = '{32'h4, 32'h4, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'h8, 32'h8};
        ept = '{1, 1, 1, 0, 0, 0, 0, 1};
        etg = '{32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h8, 32'h8};
        for (int i = 0; i < 8; i++) begin
            drive_update(32'h0, tg[i], tk[i], pr[i]);
            tick();
            expect_lookup(32'h0, 1'b1, ept[i], etg[i]);
            #1;
            exp = exp_q.pop_front();
            got = {bi.Hit_F, bi.Predict_Taken_F, bi.PC_Prediction_F};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL counter_walk_step%0d: got %h want %h", i, got, exp);
            end
        end
        expect_count();
        ce = cnt_q.pop_front();
        n_vec++;
        if (bi.Mispredict_Count !== ce) begin
            n_err++;
            $display("FAIL counter_walk_count: got %h want %h", bi.Mispredict_Count, ce);
        end
    endtask

    task automatic test_alias();
        logic [31:0] pcs[6], etg[6];
        logic        eh[6];
        logic [33:0] got, exp;
        pcs = '{32'h0, 32'h40, 32'h43, 32'h100, 32'h40, 32'h0};
        eh  = '{0, 1, 1, 0, 0, 0};
        etg = '{32'h0, 32'h80, 32'h80, 32'h0, 32'h0, 32'h0};
        drive_update(32'h40, 32'h80, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                bi.Flush_BTB = 1'b1;
                tick();
                drive_update(32'h100, 32'h999, 1'b0, 1'b0);
                tick();
            end
            expect_lookup(pcs[i], eh[i], eh[i], etg[i]);
            #1;
            exp = exp_q.pop_front();
            got = {bi.Hit_F, bi.Predict_Taken_F, bi.PC_Prediction_F};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL alias_%0d pc=%h: got %h want %h", i, pcs[i], got, exp);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] pcs[4];
        logic [33:0] got, exp;
        logic [15:0] ce;
        pcs = '{32'h4, 32'h8, 32'hC, 32'h10};
        for (int i = 0; i < 3; i++) begin
            drive_update(pcs[i], pcs[i] * 11, 1'b1, 1'b0);
            tick();
        end
        for (int pass = 0; pass < 2; pass++) begin
            if (pass == 1) begin
                bi.Flush_BTB = 1'b1;
                drive_update(32'h10, 32'h11, 1'b1, 1'b0);
                tick();
            end
            for (int i = 0; i < 4; i++) begin
                if (pass == 0 && i < 3) expect_lookup(pcs[i], 1'b1, 1'b1, pcs[i] * 11);
                else expect_lookup(pcs[i], 1'b0, 1'b0, 32'h0);
                #1;
                exp = exp_q.pop_front();
                got = {bi.Hit_F, bi.Predict_Taken_F, bi.PC_Prediction_F};
                n_vec++;
                if (got !== exp) begin
                    n_err++;
                    $display("FAIL flush_p%0d pc=%h: got %h want %h", pass, pcs[i], got, exp);
                end
            end
        end
        expect_count();
        ce = cnt_q.pop_front();
        n_vec++;
        if (bi.Mispredict_Count !== ce) begin
            n_err++;
            $display("FAIL flush_count: got %h want %h", bi.Mispredict_Count, ce);
        end
    endtask

    task automatic test_flush_hit();
        logic [33:0] got, exp;
        drive_update(32'h20, 32'h200, 1'b1, 1'b1);
        tick();
        expect_lookup(32'h20, 1'b1, 1'b1, 32'h200);
        for (int i = 0; i < 2; i++) begin
            #1;
            exp = exp_q.pop_front();
            got = {bi.Hit_F, bi.Predict_Taken_F, bi.PC_Prediction_F};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL flush_hit_step%0d: got %h want %h", i, got, exp);
            end
            if (i == 0) begin
                bi.Flush_BTB = 1'b1;
                drive_update(32'h20, 32'h300, 1'b1, 1'b0);
                tick();
                expect_lookup(32'h20, 1'b0, 1'b0, 32'h0);
            end
        end
    endtask

    task automatic test_valid_e_zero();
        logic [33:0] got, exp;
        logic [15:0] ce;
        drive_update(32'h24, 32'h240, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            bi.Valid_E         = 1'b0;
            bi.PC_E            = (i == 0) ? 32'h24 : 32'h28;
            bi.PC_Target_E     = 32'h999;
            bi.Branch_Taken_E  = (i == 1);
            bi.Predict_Taken_E = (i == 0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            if (i == 0) expect_lookup(32'h24, 1'b1, 1'b1, 32'h240);
            else expect_lookup(32'h28, 1'b0, 1'b0, 32'h0);
            #1;
            exp = exp_q.pop_front();
            got = {bi.Hit_F, bi.Predict_Taken_F, bi.PC_Prediction_F};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL valid_e_zero_%0d: got %h want %h", i, got, exp);
            end
        end
        expect_count();
        ce = cnt_q.pop_front();
        n_vec++;
        if (bi.Mispredict_Count !== ce) begin
            n_err++;
            $display("FAIL valid_e_zero_count: got %h want %h", bi.Mispredict_Count, ce);
        end
    endtask

    task automatic test_stats();
        logic        tk[5], pr[5];
        logic [15:0] base, ce;
        tk = '{1, 0, 1, 0, 0};
        pr = '{0, 1, 1, 0, 1};
        base = mis_exp;
        for (int i = 0; i < 5; i++) begin
            drive_update(32'h30, 32'h300, tk[i], pr[i]);
            tick();
        end
        cnt_q.push_back(base + 16'd3);
        expect_count();
        for (int i = 0; i < 2; i++) begin
            ce = cnt_q.pop_front();
            n_vec++;
            if (bi.Mispredict_Count !== ce) begin
                n_err++;
                $display("FAIL stats_%0d: got %h want %h", i, bi.Mispredict_Count, ce);
            end
        end
    endtask

    task automatic test_saturate();
        logic [3:0] ce;
        for (int n = 1; n <= 20; n++) begin
            bs.Valid_E         = 1'b1;
            bs.PC_E            = 32'(n) << 2;
            bs.PC_Target_E     = 32'h1000;
            bs.Branch_Taken_E  = 1'b1;
            bs.Predict_Taken_E = 1'b0;
            tick();
            if (n == 14 || n == 15 || n == 20) begin
                ce = (n >= 15) ? 4'hF : 4'(n);
                n_vec++;
                if (bs.Mispredict_Count !== ce) begin
                    n_err++;
                    $display("FAIL saturate_n%0d: got %h want %h", n, bs.Mispredict_Count, ce);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [33:0] got, exp;
        expect_lookup(32'h30, 1'b1, 1'b0, 32'h300);
        #1;
        exp = exp_q.pop_front();
        got = {bi.Hit_F, bi.Predict_Taken_F, bi.PC_Prediction_F};
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL pre_reset_lookup: got %h want %h", got, exp);
        end
        drive_update(32'h60, 32'h600, 1'b1, 1'b0);
        bs.Valid_E = 1'b1;
        #1;
        rst_n = 1'b0;
        mis_exp = 16'h0;
        expect_lookup(32'h30, 1'b0, 1'b0, 32'h0);
        #1;
        exp = exp_q.pop_front();
        got = {bi.Hit_F, bi.Predict_Taken_F, bi.PC_Prediction_F};
        n_vec += 3;
        if (got !== exp) begin
            n_err++;
            $display("FAIL async_reset_lookup: got %h want %h", got, exp);
        end
        if (bi.Mispredict_Count !== 16'h0) begin
            n_err++;
            $display("FAIL async_reset_count: got %h want 0", bi.Mispredict_Count);
        end
        if (bs.Mispredict_Count !== 4'h0) begin
            n_err++;
            $display("FAIL async_reset_sat_count: got %h want 0", bs.Mispredict_Count);
        end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        expect_lookup(32'h60, 1'b0, 1'b0, 32'h0);
        #1;
        exp = exp_q.pop_front();
        got = {bi.Hit_F, bi.Predict_Taken_F, bi.PC_Prediction_F};
        n_vec += 2;
        if (got !== exp) begin
            n_err++;
            $display("FAIL reset_overrides_update: got %h want %h", got, exp);
        end
        if (bi.Mispredict_Count !== mis_exp) begin
            n_err++;
            $display("FAIL post_reset_count: got %h want %h", bi.Mispredict_Count, mis_exp);
        end
    endtask

    initial begin
        bi.PC_F = 32'h0; bi.PC_E = 32'h0; bi.PC_Target_E = 32'h0;
        bi.Valid_E = 1'b0; bi.Branch_Taken_E = 1'b0; bi.Predict_Taken_E = 1'b0;
        bi.Flush_BTB = 1'b0;
        bs.PC_F = 32'h0; bs.PC_E = 32'h0; bs.PC_Target_E = 32'h0;
        bs.Valid_E = 1'b0; bs.Branch_Taken_E = 1'b0; bs.Predict_Taken_E = 1'b0;
        bs.Flush_BTB = 1'b0;
        #3;
        test_reset();
        test_allocate();
        test_counter_walk();
        test_alias();
        test_flush();
        test_flush_hit();
        test_valid_e_zero();
        test_stats();
        test_saturate();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
